// File: rtl/tx_data_send_if.sv
// SpaceWire transmit encoder interface: link-FSM permissions, character sources,
// handshakes, credit feedback and the Data-Strobe line pair.
interface tx_data_send_if;
    logic       enable_tx;
    logic       send_null_tx;
    logic       send_fct_tx;
    logic       send_char_tx;
    logic       tickin_tx;
    logic [7:0] timein_tx;
    logic       fct_req;
    logic       data_valid;
    logic [8:0] data_in;
    logic       rx_got_fct;
    logic       dout;
    logic       sout;
    logic       data_ack;
    logic       tick_ack;
    logic       fct_sent;
    logic       credit_error;
    logic [5:0] credit;

    modport master (
        output enable_tx, send_null_tx, send_fct_tx, send_char_tx,
        output tickin_tx, timein_tx, fct_req, data_valid, data_in, rx_got_fct,
        input  dout, sout, data_ack, tick_ack, fct_sent, credit_error, credit
    );

    modport slave (
        input  enable_tx, send_null_tx, send_fct_tx, send_char_tx,
        input  tickin_tx, timein_tx, fct_req, data_valid, data_in, rx_got_fct,
        output dout, sout, data_ack, tick_ack, fct_sent, credit_error, credit
    );
endinterface

// File: rtl/tx_data_send.sv
// SpaceWire transmit character encoder/serializer: picks the next character by priority,
// adds odd parity, shifts one bit per clock onto Data-Strobe lines and keeps TX credit.
module tx_data_send #(
    parameter int CREDIT_MAX = 56,
    parameter int FCT_CREDIT = 8
) (
    input logic           posedge_clk,
    input logic           tx_resetn,
    tx_data_send_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
    typedef enum logic [2:0] {CH_DATA, CH_FCT, CH_EOP, CH_EEP, CH_ESC} char_t;

    state_t     state_q, state_d;
    logic       dout_q, dout_d;
    logic       sout_q, sout_d;
    logic [8:0] sh_q, sh_d;
    logic [3:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic [5:0] credit_q, credit_d;
    logic       tick_pend_q, tick_pend_d;
    logic [7:0] tick_time_q, tick_time_d;
    logic       esc_pend_q, esc_pend_d;
    char_t      esc_kind_q, esc_kind_d;
    logic [7:0] esc_byte_q, esc_byte_d;

    logic       select;
    logic       data_ack, tick_ack, fct_sent, credit_error, add_ok;
    char_t      ch_kind;
    logic [7:0] ch_byte;
    logic       esc_set;
    char_t      esc_set_kind;
    logic [7:0] esc_set_byte;
    logic       ctl;
    logic [7:0] payload;
    logic [9:0] frame;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge posedge_clk or negedge tx_resetn) begin
        if (!tx_resetn) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.enable_tx)  state_d = ST_SHIFT;
            ST_SHIFT: if (!bus.enable_tx) state_d = ST_IDLE;
        endcase
    end

    // A new character is chosen on the cycle the previous one's last bit is on dout.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        select       = bus.enable_tx && (state_q == ST_IDLE || cnt_q == 4'd0);
        ch_kind      = CH_ESC;
        ch_byte      = 8'h00;
        data_ack     = 1'b0;
        tick_ack     = 1'b0;
        fct_sent     = 1'b0;
        esc_set      = 1'b0;
        esc_set_kind = CH_FCT;
        esc_set_byte = 8'h00;
        if (select) begin
            if (esc_pend_q) begin
                ch_kind = esc_kind_q;
                ch_byte = esc_byte_q;
            end else if (tick_pend_q && bus.send_char_tx) begin
                tick_ack     = 1'b1;
                esc_set      = 1'b1;
                esc_set_kind = CH_DATA;
                esc_set_byte = tick_time_q;
            end else if (bus.fct_req && bus.send_fct_tx) begin
                ch_kind  = CH_FCT;
                fct_sent = 1'b1;
            end else if (bus.data_valid && bus.send_char_tx && credit_q != 6'd0) begin
                data_ack = 1'b1;
                if (bus.data_in[8]) ch_kind = bus.data_in[0] ? CH_EEP : CH_EOP;
                else begin
                    ch_kind = CH_DATA;
                    ch_byte = bus.data_in[7:0];
                end
            end else begin
                esc_set = 1'b1;
            end
        end
    end

    // Wire order is frame[0] first: P, C, then data/control bits.
    always_comb begin
        ctl     = 1'b1;
        payload = 8'h00;
        case (ch_kind)
            CH_DATA: begin ctl = 1'b0; payload = ch_byte; end
            CH_FCT:  payload = 8'b00;
            CH_EOP:  payload = 8'b01;
            CH_EEP:  payload = 8'b10;
            default: payload = 8'b11;
        endcase
        frame = {payload, ctl, ~(par_q ^ ctl)};
    end

    always_comb begin
        add_ok       = ({1'b0, credit_q} + 7'(FCT_CREDIT)) <= 7'(CREDIT_MAX);
        credit_error = bus.enable_tx && bus.rx_got_fct && !add_ok;

        dout_d      = 1'b0;
        sout_d      = 1'b0;
        sh_d        = 9'd0;
        cnt_d       = 4'd0;
        par_d       = 1'b0;
        credit_d    = 6'd0;
        tick_pend_d = 1'b0;
        tick_time_d = tick_time_q;
        esc_pend_d  = 1'b0;
        esc_kind_d  = esc_kind_q;
        esc_byte_d  = esc_byte_q;
        if (bus.enable_tx) begin
            if (select) begin
                dout_d     = frame[0];
                sh_d       = frame[9:1];
                cnt_d      = ctl ? 4'd3 : 4'd9;
                par_d      = ^payload;
                esc_pend_d = esc_set;
                esc_kind_d = esc_set_kind;
                esc_byte_d = esc_set_byte;
            end else begin
                dout_d     = sh_q[0];
                sh_d       = {1'b0, sh_q[8:1]};
                cnt_d      = cnt_q - 4'd1;
                par_d      = par_q;
                esc_pend_d = esc_pend_q;
            end
            // Strobe toggles only when data repeats, so exactly one line changes per bit.
            sout_d      = (dout_d == dout_q) ? ~sout_q : sout_q;
            credit_d    = 6'({1'b0, credit_q}
                             + ((bus.rx_got_fct && add_ok) ? 7'(FCT_CREDIT) : 7'd0)
                             - {6'd0, data_ack});
            tick_pend_d = bus.tickin_tx ? 1'b1 : (tick_ack ? 1'b0 : tick_pend_q);
            tick_time_d = bus.tickin_tx ? bus.timein_tx : tick_time_q;
        end
    end

    always_ff @(posedge posedge_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            dout_q      <= 1'b0;
            sout_q      <= 1'b0;
            sh_q        <= 9'd0;
            cnt_q       <= 4'd0;
            par_q       <= 1'b0;
            credit_q    <= 6'd0;
            tick_pend_q <= 1'b0;
            tick_time_q <= 8'h00;
            esc_pend_q  <= 1'b0;
            esc_kind_q  <= CH_FCT;
            esc_byte_q  <= 8'h00;
        end else begin
            dout_q      <= dout_d;
            sout_q      <= sout_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            credit_q    <= credit_d;
            tick_pend_q <= tick_pend_d;
            tick_time_q <= tick_time_d;
            esc_pend_q  <= esc_pend_d;
            esc_kind_q  <= esc_kind_d;
            esc_byte_q  <= esc_byte_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.sout         = sout_q;
    assign bus.data_ack     = data_ack;
    assign bus.tick_ack     = tick_ack;
    assign bus.fct_sent     = fct_sent;
    assign bus.credit_error = credit_error;
    assign bus.credit       = credit_q;
endmodule
